exception_unit: RTL and testbench
=================================

Name: exception_unit

Overview:
- Producer side of the COP0 exception interface: collects exception flags from the memory stage and raises interrupt lines.
- Prioritises them and generates the commit pulse for COP0 (exp_en, exp_code, exp_epc, exp_bd, exp_badvaddr*).
- Kills younger instructions and redirects fetch to the exception vector or, on ERET, to EPC.
- Consumes COP0's epc_address, allow_interrupt and interrupt_flag; sits between the MEM stage, COP0 and the fetch unit.

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, exception/interrupt redirect target
- HW_INT_W, 6, number of external hardware interrupt lines

Ports:
- clk  in  1  clock, single clock domain
- rst_n  in  1  reset, synchronous, active-low
- mem_valid  in  1  MEM stage holds a valid instruction
- mem_pc  in  32  PC of the MEM-stage instruction
- mem_bd  in  1  MEM instruction is in a branch delay slot
- mem_adel, mem_ades, mem_sys, mem_bp, mem_ri, mem_ov  in  1 each  exception flags
- mem_eret  in  1  MEM instruction is ERET
- mem_badvaddr  in  32  faulting address for AdEL/AdES
- hw_int  in  HW_INT_W  asynchronous external interrupt lines
- sw_int  in  2  COP0 Cause[9:8]
- epc_address  in  32  from COP0
- allow_interrupt  in  1  from COP0
- interrupt_flag  in  8  Status IM from COP0
- redirect_ready  in  1  fetch accepts redirect
- flush  out  1  kill IF..MEM, suppress MEM writeback
- exp_en, exp_badvaddr_en, exp_bd  out  1 each  to COP0
- exp_code  out  5  to COP0
- exp_badvaddr, exp_epc  out  32  to COP0
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  32  redirect target
- int_pending  out  8  {hw_sync, sw_int}, for Cause IP readback

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; flush, exp_en, exp_badvaddr_en, exp_bd, redirect_valid all 0; exp_code=0; exp_badvaddr, exp_epc, redirect_pc=0; synchroniser flops=0. Reset mid-REDIRECT aborts the redirect.
- ip = {hw_sync[HW_INT_W-1:0], sw_int}; int_pending = ip (zero-extended to 8 bits).
- irq = allow_interrupt & |(ip & interrupt_flag).
- Priority, evaluated only in IDLE with mem_valid=1:
  - irq: code 0
  - AdEL: code 4
  - AdES: code 5
  - RI: code 10
  - Ov: code 12
  - Sys: code 8
  - Bp: code 9
  - ERET: lowest; never coincides with an exception (a faulting ERET takes the exception instead).
- Cycle N, exception/interrupt chosen:
  - flush=1 combinationally.
  - At edge N+1 register: exp_en=1 for exactly one cycle; exp_code; exp_bd=mem_bd; exp_epc = mem_bd ? mem_pc-32'd4 : mem_pc (mod 2^32); exp_badvaddr_en=1 only for AdEL/AdES, with exp_badvaddr=mem_badvaddr.
  - redirect_pc=EXC_VECTOR, redirect_valid=1, state goes to REDIRECT.
- Cycle N, ERET chosen: flush=1; at N+1 redirect_pc=epc_address sampled in cycle N, redirect_valid=1, exp_en stays 0, state goes to REDIRECT.
- REDIRECT state:
  - flush=1 and redirect_valid=1 held, redirect_pc stable, all MEM inputs ignored, no new exception or interrupt taken.
  - On redirect_valid & redirect_ready: next cycle redirect_valid=0, flush=0, state=IDLE.
  - redirect_ready already high at N+1 gives a minimum 1-cycle redirect.
- mem_valid=0 in IDLE: nothing taken (pending interrupts wait for a valid instruction), flush=0.
- State machine: IDLE, REDIRECT; no other states.

Optional Feature:
- Macro EXC_IRQ_SYNC_EN.
- Defined: hw_int passes through a 2-flop synchroniser; hw_sync lags hw_int by 2 cycles.
- Undefined: a single register stage; 1-cycle lag.
- sw_int is never synchronised in either case.

Decomposition:
- Shared package holds:
  - exc_code_t enum: EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_SYS=8, EXC_BP=9, EXC_RI=10, EXC_OV=12.
  - exc_state_t {IDLE, REDIRECT}.
  - EXC_VECTOR default constant.
- One sub-module, irq_sync: per-bit synchroniser, depth selected by EXC_IRQ_SYNC_EN.

Test Plan:
- mem_valid=1, mem_ov=1, mem_pc=32'h8000_0010, mem_bd=0 -> flush same cycle; next cycle exp_en=1, exp_code=12, exp_epc=32'h8000_0010, exp_badvaddr_en=0; redirect_pc=32'hBFC0_0380.
- mem_adel=1, mem_bd=1, mem_pc=32'h8000_0024, mem_badvaddr=32'h0000_0003 -> exp_code=4, exp_bd=1, exp_epc=32'h8000_0020, exp_badvaddr_en=1, exp_badvaddr=32'h0000_0003.
- hw_int[0]=1, interrupt_flag=8'h04, allow_interrupt=1, mem_valid=1 -> exp_code=0 two cycles after the hw_int rise (macro on); same stimulus with allow_interrupt=0 -> no exp_en.
- mem_eret=1, epc_address=32'h8000_1000 -> redirect_pc=32'h8000_1000, exp_en stays 0.
- redirect_ready held 0 for 3 cycles after redirect -> redirect_valid and flush stay 1; a new mem_sys in that window is ignored; ready=1 -> IDLE next cycle.
- rst_n=0 during REDIRECT -> next cycle redirect_valid=0, flush=0, exp_en=0.

Source files
------------

// File: rtl/exception_unit_pkg.sv
// Shared types and constants for the exception unit.
//   exc_code_t  : COP0 Cause.ExcCode values produced by this block
//   exc_state_t : redirect handshake state
//   mem_exc_t   : exception flags raised by the MEM stage
//   exc_select  : priority pick among interrupt and MEM exception flags
package exception_unit_pkg;

    localparam int unsigned XLEN             = 32;
    localparam int unsigned CODE_W           = 5;
    localparam int unsigned IP_W             = 8;
    localparam int unsigned HW_INT_W_DEFAULT = 6;
    localparam logic [XLEN-1:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    typedef enum logic [CODE_W-1:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_t;

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } exc_state_t;

    typedef struct packed {
        logic adel;
        logic ades;
        logic ri;
        logic ov;
        logic sys;
        logic bp;
    } mem_exc_t;

    // Anything (interrupt or MEM fault) that vectors to the exception handler.
    function automatic logic exc_any(input logic irq, input mem_exc_t f);
        return irq | (|f);
    endfunction

    // Fixed priority: interrupt, AdEL, AdES, RI, Ov, Sys, Bp.
    function automatic exc_code_t exc_select(input logic irq, input mem_exc_t f);
        exc_code_t code;
        code = EXC_INT;
        if (irq)         code = EXC_INT;
        else if (f.adel) code = EXC_ADEL;
        else if (f.ades) code = EXC_ADES;
        else if (f.ri)   code = EXC_RI;
        else if (f.ov)   code = EXC_OV;
        else if (f.sys)  code = EXC_SYS;
        else if (f.bp)   code = EXC_BP;
        return code;
    endfunction

    // Address errors are the only codes that report BadVAddr.
    function automatic logic exc_has_badvaddr(input exc_code_t code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/exception_unit_irq_sync.sv
// Synchroniser for the external interrupt lines.
// Build option: EXC_IRQ_SYNC_EN defined -> two flops per bit (2-cycle lag),
// undefined -> one register stage (1-cycle lag).
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   async_in   : raw hw interrupt lines
//   sync_out   : registered/synchronised lines
module exception_unit_irq_sync #(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] async_in,
    output logic [W-1:0] sync_out
);

`ifdef EXC_IRQ_SYNC_EN
    logic [W-1:0] meta;

    // Two-stage metastability filter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta     <= '0;
            sync_out <= '0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end
`else
    // Single capture stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_out <= '0;
        end else begin
            sync_out <= async_in;
        end
    end
`endif

endmodule

// File: rtl/exception_unit.sv
// Exception unit: prioritises MEM-stage exceptions and interrupts, pulses the
// COP0 commit interface, kills younger instructions and redirects fetch to the
// exception vector (or to EPC on ERET).
// Build option: EXC_IRQ_SYNC_EN selects a 2-flop hw_int synchroniser.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   mem_*                      : MEM-stage instruction, PC, BD flag, fault flags
//   hw_int, sw_int             : external and software interrupt sources
//   epc_address                : EPC from COP0 (ERET target)
//   allow_interrupt            : global interrupt enable from COP0
//   interrupt_flag             : Status.IM from COP0
//   redirect_ready             : fetch accepts the redirect
//   flush                      : combinational kill of IF..MEM
//   exp_*                      : registered commit pulse to COP0
//   redirect_valid/redirect_pc : registered redirect request to fetch
//   int_pending                : pending-interrupt vector for Cause.IP
module exception_unit
    import exception_unit_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
    parameter int unsigned HW_INT_W   = HW_INT_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mem_valid,
    input  logic [31:0]         mem_pc,
    input  logic                mem_bd,
    input  logic                mem_adel,
    input  logic                mem_ades,
    input  logic                mem_sys,
    input  logic                mem_bp,
    input  logic                mem_ri,
    input  logic                mem_ov,
    input  logic                mem_eret,
    input  logic [31:0]         mem_badvaddr,
    input  logic [HW_INT_W-1:0] hw_int,
    input  logic [1:0]          sw_int,
    input  logic [31:0]         epc_address,
    input  logic                allow_interrupt,
    input  logic [7:0]          interrupt_flag,
    input  logic                redirect_ready,
    output logic                flush,
    output logic                exp_en,
    output logic                exp_badvaddr_en,
    output logic                exp_bd,
    output logic [4:0]          exp_code,
    output logic [31:0]         exp_badvaddr,
    output logic [31:0]         exp_epc,
    output logic                redirect_valid,
    output logic [31:0]         redirect_pc,
    output logic [7:0]          int_pending
);

    localparam int unsigned IP_RAW_W = HW_INT_W + 2;

    logic [HW_INT_W-1:0] hw_sync;
    logic [IP_RAW_W-1:0] ip_raw;
    logic [IP_W-1:0]     ip;
    logic                irq;
    mem_exc_t            mem_exc;
    exc_code_t           sel_code;
    logic                take_exc;
    logic                take_eret;

    exc_state_t          state;
    exc_state_t          state_d;
    logic                exp_en_d;
    logic                exp_badvaddr_en_d;
    logic                exp_bd_d;
    logic [CODE_W-1:0]   exp_code_d;
    logic [XLEN-1:0]     exp_badvaddr_d;
    logic [XLEN-1:0]     exp_epc_d;
    logic                redirect_valid_d;
    logic [XLEN-1:0]     redirect_pc_d;

    exception_unit_irq_sync #(
        .W (HW_INT_W)
    ) u_irq_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (hw_int),
        .sync_out (hw_sync)
    );

    // Pending interrupts and the masked, globally enabled request.
    assign ip_raw      = {hw_sync, sw_int};
    assign ip          = IP_W'(ip_raw);
    assign int_pending = ip;
    assign irq         = allow_interrupt & (|(ip & interrupt_flag));

    assign mem_exc = '{adel: mem_adel, ades: mem_ades, ri: mem_ri,
                       ov: mem_ov, sys: mem_sys, bp: mem_bp};
    assign sel_code = exc_select(irq, mem_exc);

    // Next-state, commit payload and redirect target.
    always_comb begin
        state_d           = state;
        flush             = 1'b0;
        take_exc          = 1'b0;
        take_eret         = 1'b0;
        exp_en_d          = 1'b0;
        exp_badvaddr_en_d = 1'b0;
        exp_bd_d          = exp_bd;
        exp_code_d        = exp_code;
        exp_badvaddr_d    = exp_badvaddr;
        exp_epc_d         = exp_epc;
        redirect_valid_d  = redirect_valid;
        redirect_pc_d     = redirect_pc;

        case (state)
            IDLE: begin
                // Interrupts wait for a valid instruction to attach EPC to.
                if (rst_n && mem_valid) begin
                    take_exc  = exc_any(irq, mem_exc);
                    take_eret = !take_exc && mem_eret;
                end

                if (take_exc) begin
                    flush             = 1'b1;
                    state_d           = REDIRECT;
                    exp_en_d          = 1'b1;
                    exp_code_d        = sel_code;
                    exp_bd_d          = mem_bd;
                    // A delay-slot fault restarts at the branch.
                    exp_epc_d         = mem_bd ? (mem_pc - 32'd4) : mem_pc;
                    exp_badvaddr_en_d = exc_has_badvaddr(sel_code);
                    if (exc_has_badvaddr(sel_code)) begin
                        exp_badvaddr_d = mem_badvaddr;
                    end
                    redirect_valid_d  = 1'b1;
                    redirect_pc_d     = EXC_VECTOR;
                end else if (take_eret) begin
                    flush            = 1'b1;
                    state_d          = REDIRECT;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = epc_address;
                end
            end

            REDIRECT: begin
                // Pipeline stays killed until fetch takes the new PC.
                flush = 1'b1;
                if (redirect_valid && redirect_ready) begin
                    state_d          = IDLE;
                    redirect_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            exp_en          <= 1'b0;
            exp_badvaddr_en <= 1'b0;
            exp_bd          <= 1'b0;
            exp_code        <= '0;
            exp_badvaddr    <= '0;
            exp_epc         <= '0;
            redirect_valid  <= 1'b0;
            redirect_pc     <= '0;
        end else begin
            state           <= state_d;
            exp_en          <= exp_en_d;
            exp_badvaddr_en <= exp_badvaddr_en_d;
            exp_bd          <= exp_bd_d;
            exp_code        <= exp_code_d;
            exp_badvaddr    <= exp_badvaddr_d;
            exp_epc         <= exp_epc_d;
            redirect_valid  <= redirect_valid_d;
            redirect_pc     <= redirect_pc_d;
        end
    end

endmodule

// File: tb/tb_exception_unit.sv
// Directed bench for exception_unit with a cycle-level reference model.
module tb_exception_unit;

    localparam int unsigned HW_INT_W = 6;
    localparam logic [31:0] VEC      = 32'hBFC0_0380;
`ifdef EXC_IRQ_SYNC_EN
    localparam int LAG = 2;
`else
    localparam int LAG = 1;
`endif

    logic                clk;
    logic                rst_n;
    logic                mem_valid;
    logic [31:0]         mem_pc;
    logic                mem_bd;
    logic                mem_adel, mem_ades, mem_sys, mem_bp, mem_ri, mem_ov;
    logic                mem_eret;
    logic [31:0]         mem_badvaddr;
    logic [HW_INT_W-1:0] hw_int;
    logic [1:0]          sw_int;
    logic [31:0]         epc_address;
    logic                allow_interrupt;
    logic [7:0]          interrupt_flag;
    logic                redirect_ready;
    logic                flush;
    logic                exp_en, exp_badvaddr_en, exp_bd;
    logic [4:0]          exp_code;
    logic [31:0]         exp_badvaddr, exp_epc;
    logic                redirect_valid;
    logic [31:0]         redirect_pc;
    logic [7:0]          int_pending;

    exception_unit #(
        .EXC_VECTOR (VEC),
        .HW_INT_W   (HW_INT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_valid       (mem_valid),
        .mem_pc          (mem_pc),
        .mem_bd          (mem_bd),
        .mem_adel        (mem_adel),
        .mem_ades        (mem_ades),
        .mem_sys         (mem_sys),
        .mem_bp          (mem_bp),
        .mem_ri          (mem_ri),
        .mem_ov          (mem_ov),
        .mem_eret        (mem_eret),
        .mem_badvaddr    (mem_badvaddr),
        .hw_int          (hw_int),
        .sw_int          (sw_int),
        .epc_address     (epc_address),
        .allow_interrupt (allow_interrupt),
        .interrupt_flag  (interrupt_flag),
        .redirect_ready  (redirect_ready),
        .flush           (flush),
        .exp_en          (exp_en),
        .exp_badvaddr_en (exp_badvaddr_en),
        .exp_bd          (exp_bd),
        .exp_code        (exp_code),
        .exp_badvaddr    (exp_badvaddr),
        .exp_epc         (exp_epc),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .int_pending     (int_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference priority, straight from the cause-code table.
    function automatic logic [4:0] ref_code(input logic irq, input logic adel, input logic ades,
                                            input logic ri, input logic ov, input logic sys,
                                            input logic bp);
        if (irq)  return 5'd0;
        if (adel) return 5'd4;
        if (ades) return 5'd5;
        if (ri)   return 5'd10;
        if (ov)   return 5'd12;
        if (sys)  return 5'd8;
        if (bp)   return 5'd9;
        return 5'd31;
    endfunction

    // Model state: what the DUT outputs must look like after the next edge.
    bit                  m_valid = 1'b0;
    bit                  m_busy  = 1'b0;
    bit                  m_pulse = 1'b0;
    bit                  m_bven  = 1'b0;
    bit                  m_bd    = 1'b0;
    logic [31:0]         m_rpc   = '0;
    logic [31:0]         m_epc   = '0;
    logic [31:0]         m_bva   = '0;
    logic [4:0]          m_code  = '0;
    logic [HW_INT_W-1:0] m_hist [0:1];

    always @(negedge clk) begin : model
        logic [7:0] ip;
        logic       irq;
        logic       exc;
        logic       take;
        logic [4:0] code;

        ip   = {m_hist[LAG-1], sw_int};
        irq  = allow_interrupt && ((ip & interrupt_flag) != 8'h00);
        exc  = irq || mem_adel || mem_ades || mem_ri || mem_ov || mem_sys || mem_bp;
        code = ref_code(irq, mem_adel, mem_ades, mem_ri, mem_ov, mem_sys, mem_bp);
        take = rst_n && !m_busy && mem_valid && (exc || mem_eret);

        if (m_valid) begin
            chk("m_int_pending", 32'(int_pending), 32'(ip));
            chk("m_flush", 32'(flush), 32'(m_busy || take));
            chk("m_redirect_valid", 32'(redirect_valid), 32'(m_busy));
            if (m_busy) chk("m_redirect_pc", redirect_pc, m_rpc);
            chk("m_exp_en", 32'(exp_en), 32'(m_pulse));
            chk("m_exp_badvaddr_en", 32'(exp_badvaddr_en), 32'(m_pulse && m_bven));
            if (m_pulse) begin
                chk("m_exp_code", 32'(exp_code), 32'(m_code));
                chk("m_exp_bd", 32'(exp_bd), 32'(m_bd));
                chk("m_exp_epc", exp_epc, m_epc);
                if (m_bven) chk("m_exp_badvaddr", exp_badvaddr, m_bva);
            end
        end

        if (!rst_n) begin
            m_busy    = 1'b0;
            m_pulse   = 1'b0;
            m_hist[0] = '0;
            m_hist[1] = '0;
            m_valid   = 1'b1;
        end else begin
            m_pulse = take && exc;
            if (take) begin
                m_busy = 1'b1;
                m_rpc  = exc ? VEC : epc_address;
                if (exc) begin
                    m_code = code;
                    m_bd   = mem_bd;
                    m_epc  = mem_bd ? mem_pc - 32'd4 : mem_pc;
                    m_bven = (code == 5'd4) || (code == 5'd5);
                    m_bva  = mem_badvaddr;
                end
            end else if (m_busy && redirect_ready) begin
                m_busy = 1'b0;
            end
            m_hist[1] = m_hist[0];
            m_hist[0] = hw_int;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        mem_valid = 1'b0; mem_pc = '0; mem_bd = 1'b0; mem_badvaddr = '0;
        mem_adel = 1'b0; mem_ades = 1'b0; mem_sys = 1'b0; mem_bp = 1'b0;
        mem_ri = 1'b0; mem_ov = 1'b0; mem_eret = 1'b0;
    endtask

    // flags = {adel, ades, ri, ov, sys, bp, eret}
    task automatic pri(input string name, input logic [6:0] f, input logic [4:0] code);
        cyc();
        quiet();
        mem_valid = 1'b1; mem_pc = 32'h8000_0400;
        {mem_adel, mem_ades, mem_ri, mem_ov, mem_sys, mem_bp, mem_eret} = f;
        cyc();
        quiet();
        @(negedge clk);
        chk(name, 32'(exp_code), 32'(code));
        cyc();
    endtask

    initial begin
        rst_n = 1'b0; quiet();
        hw_int = '0; sw_int = '0; epc_address = '0;
        allow_interrupt = 1'b0; interrupt_flag = '0; redirect_ready = 1'b1;
        repeat (3) cyc();
        @(negedge clk);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        chk("rst_exp_en", 32'(exp_en), 32'd0);
        chk("rst_exp_code", 32'(exp_code), 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_exp_epc", exp_epc, 32'd0);
        chk("rst_int_pending", 32'(int_pending), 32'd0);
        cyc(); rst_n = 1'b1;
        cyc();

        // Overflow, not in a delay slot, minimum-length redirect.
        cyc(); quiet();
        mem_valid = 1'b1; mem_ov = 1'b1; mem_pc = 32'h8000_0010;
        @(negedge clk);
        chk("ov_flush_same_cycle", 32'(flush), 32'd1);
        chk("ov_no_pulse_yet", 32'(exp_en), 32'd0);
        cyc(); quiet();
        @(negedge clk);
        chk("ov_exp_en", 32'(exp_en), 32'd1);
        chk("ov_exp_code", 32'(exp_code), 32'd12);
        chk("ov_exp_epc", exp_epc, 32'h8000_0010);
        chk("ov_badvaddr_en", 32'(exp_badvaddr_en), 32'd0);
        chk("ov_redirect_pc", redirect_pc, 32'hBFC0_0380);
        chk("ov_redirect_valid", 32'(redirect_valid), 32'd1);
        cyc();
        @(negedge clk);
        chk("ov_back_idle_rv", 32'(redirect_valid), 32'd0);
        chk("ov_back_idle_flush", 32'(flush), 32'd0);
        chk("ov_pulse_once", 32'(exp_en), 32'd0);

        // AdEL in a delay slot.
        cyc(); quiet();
        mem_valid = 1'b1; mem_adel = 1'b1; mem_bd = 1'b1;
        mem_pc = 32'h8000_0024; mem_badvaddr = 32'h0000_0003;
        cyc(); quiet();
        @(negedge clk);
        chk("adel_code", 32'(exp_code), 32'd4);
        chk("adel_bd", 32'(exp_bd), 32'd1);
        chk("adel_epc", exp_epc, 32'h8000_0020);
        chk("adel_badvaddr_en", 32'(exp_badvaddr_en), 32'd1);
        chk("adel_badvaddr", exp_badvaddr, 32'h0000_0003);
        cyc();

        // Priority among simultaneous flags.
        pri("pri_adel_over_all", 7'b1101100, 5'd4);
        pri("pri_ades_over_ri", 7'b0110000, 5'd5);
        pri("pri_ri_over_ov_bp", 7'b0011010, 5'd10);
        pri("pri_ov_over_sys", 7'b0001100, 5'd12);
        pri("pri_sys_over_bp_eret", 7'b0000111, 5'd8);
        pri("pri_bp_alone", 7'b0000010, 5'd9);

        // EPC wraps for a delay-slot fault at PC 0.
        cyc(); quiet();
        mem_valid = 1'b1; mem_bp = 1'b1; mem_bd = 1'b1; mem_pc = 32'h0000_0000;
        cyc(); quiet();
        @(negedge clk);
        chk("epc_wrap", exp_epc, 32'hFFFF_FFFC);
        cyc();

        // Hardware interrupt through the synchroniser.
        allow_interrupt = 1'b1; interrupt_flag = 8'h04;
        cyc(); quiet();
        mem_valid = 1'b1; mem_pc = 32'h8000_0100; hw_int = 6'b000001;
        @(negedge clk);
        chk("irq_not_before_sync", 32'(flush), 32'd0);
        repeat (LAG) cyc();
        @(negedge clk);
        chk("irq_flush", 32'(flush), 32'd1);
        chk("irq_int_pending", 32'(int_pending), 32'h04);
        cyc(); quiet(); hw_int = '0;
        @(negedge clk);
        chk("irq_exp_en", 32'(exp_en), 32'd1);
        chk("irq_code", 32'(exp_code), 32'd0);
        chk("irq_epc", exp_epc, 32'h8000_0100);
        repeat (4) cyc();

        // Same stimulus with interrupts globally disabled.
        allow_interrupt = 1'b0;
        cyc(); mem_valid = 1'b1; hw_int = 6'b000001;
        repeat (LAG + 2) cyc();
        @(negedge clk);
        chk("irq_disabled_no_exp", 32'(exp_en), 32'd0);
        chk("irq_disabled_no_flush", 32'(flush), 32'd0);
        chk("irq_disabled_pending", 32'(int_pending), 32'h04);

        // Enabled, but masked by IM.
        allow_interrupt = 1'b1; interrupt_flag = 8'h08;
        repeat (2) cyc();
        @(negedge clk);
        chk("irq_masked_no_flush", 32'(flush), 32'd0);

        // Software interrupt is taken without synchroniser lag.
        cyc(); hw_int = '0; sw_int = 2'b01; interrupt_flag = 8'h01;
        @(negedge clk);
        chk("swint_flush_same_cycle", 32'(flush), 32'd1);
        cyc(); quiet(); sw_int = 2'b00;
        @(negedge clk);
        chk("swint_code", 32'(exp_code), 32'd0);
        repeat (4) cyc();
        allow_interrupt = 1'b0; interrupt_flag = 8'h00;

        // ERET redirects to EPC sampled in the decision cycle.
        cyc(); quiet();
        mem_valid = 1'b1; mem_eret = 1'b1; epc_address = 32'h8000_1000;
        @(negedge clk);
        chk("eret_flush", 32'(flush), 32'd1);
        cyc(); quiet(); epc_address = 32'h1234_5678;
        @(negedge clk);
        chk("eret_redirect_pc", redirect_pc, 32'h8000_1000);
        chk("eret_redirect_valid", 32'(redirect_valid), 32'd1);
        chk("eret_no_exp_en", 32'(exp_en), 32'd0);
        cyc();

        // Fetch stalls the redirect; a new syscall meanwhile is ignored.
        cyc(); quiet();
        redirect_ready = 1'b0;
        mem_valid = 1'b1; mem_sys = 1'b1; mem_pc = 32'h8000_0200;
        cyc(); mem_pc = 32'h8000_0300;
        @(negedge clk);
        chk("hold_first_pulse", 32'(exp_en), 32'd1);
        chk("hold_first_epc", exp_epc, 32'h8000_0200);
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge clk);
            chk("hold_rv", 32'(redirect_valid), 32'd1);
            chk("hold_flush", 32'(flush), 32'd1);
            chk("hold_no_new_exp", 32'(exp_en), 32'd0);
            chk("hold_rpc", redirect_pc, 32'hBFC0_0380);
        end
        cyc(); quiet(); redirect_ready = 1'b1;
        @(negedge clk);
        chk("hold_handshake_rv", 32'(redirect_valid), 32'd1);
        cyc();
        @(negedge clk);
        chk("hold_release_rv", 32'(redirect_valid), 32'd0);
        chk("hold_release_flush", 32'(flush), 32'd0);

        // Reset while a redirect is outstanding.
        cyc(); quiet();
        redirect_ready = 1'b0; mem_valid = 1'b1; mem_bp = 1'b1;
        cyc(); quiet();
        @(negedge clk);
        chk("rstmid_in_redirect", 32'(redirect_valid), 32'd1);
        cyc(); rst_n = 1'b0;
        cyc();
        @(negedge clk);
        chk("rstmid_rv", 32'(redirect_valid), 32'd0);
        chk("rstmid_flush", 32'(flush), 32'd0);
        chk("rstmid_exp_en", 32'(exp_en), 32'd0);
        cyc(); rst_n = 1'b1; redirect_ready = 1'b1;
        repeat (3) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
